// File: rtl/pipe_pkg.sv
// Shared widths, ID/EX control bundle and hazard FSM state for the ID/EX stage.
// Used by id_ex_hazard_stage (optional HAZARD_STATS_EN counters) and load_use_detect.
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int ALUC_W = 4;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic reg_wr;
    logic alu_src;
    logic mem_wr;
    logic mem_to_reg;
    logic valid;
  } ctrl_t;

  // A bubble carries no side effects: every control bit low.
  localparam ctrl_t BUBBLE_CTRL = ctrl_t'(5'b00000);

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare: a valid load sitting in ID/EX whose non-zero
// target register is read by the valid instruction currently in ID.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int REG_W_P = REG_W
) (
  input  logic               i_Valid_ID,
  input  logic [REG_W_P-1:0] i_Rs_ID,
  input  logic [REG_W_P-1:0] i_Rt_ID,
  input  logic               i_UsesRs_ID,
  input  logic               i_UsesRt_ID,
  input  logic               i_MemtoReg_ID_EX,
  input  logic               i_RegWr_ID_EX,
  input  logic               i_Valid_ID_EX,
  input  logic [REG_W_P-1:0] i_RegTarget_ID_EX,
  output logic               o_LoadUse
);

  logic w_is_load;
  logic w_rs_hit;
  logic w_rt_hit;

  assign w_is_load = i_MemtoReg_ID_EX & i_RegWr_ID_EX & i_Valid_ID_EX &
                     (i_RegTarget_ID_EX != {REG_W_P{1'b0}});
  assign w_rs_hit  = i_UsesRs_ID & (i_Rs_ID == i_RegTarget_ID_EX);
  assign w_rt_hit  = i_UsesRt_ID & (i_Rt_ID == i_RegTarget_ID_EX);
  assign o_LoadUse = w_is_load & i_Valid_ID & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with one-cycle load-use interlock, branch flush and hold.
// Define HAZARD_STATS_EN to add saturating StallCnt/FlushCnt statistics outputs.
module id_ex_hazard_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int REG_W_P  = REG_W,
  parameter int ALUC_W_P = ALUC_W,
  parameter int CNT_W    = 16
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic                i_Valid_ID,
  input  logic [REG_W_P-1:0]  i_Rs_ID,
  input  logic [REG_W_P-1:0]  i_Rt_ID,
  input  logic [REG_W_P-1:0]  i_Rd_ID,
  input  logic                i_UsesRs_ID,
  input  logic                i_UsesRt_ID,
  input  logic [DATA_W_P-1:0] i_BusA_ID,
  input  logic [DATA_W_P-1:0] i_BusB_ID,
  input  logic [DATA_W_P-1:0] i_Imm32_ID,
  input  logic                i_RegWr_ID,
  input  logic                i_RegDst_ID,
  input  logic                i_ALUSrc_ID,
  input  logic                i_MemWr_ID,
  input  logic                i_MemtoReg_ID,
  input  logic [ALUC_W_P-1:0] i_ALUctr_ID,
  input  logic                i_Flush_ID_EX,
  input  logic                i_Hold,
  output logic [REG_W_P-1:0]  o_Rs_ID_EX,
  output logic [REG_W_P-1:0]  o_Rt_ID_EX,
  output logic [REG_W_P-1:0]  o_RegTarget_ID_EX,
  output logic [DATA_W_P-1:0] o_BusA_ID_EX,
  output logic [DATA_W_P-1:0] o_BusB_ID_EX,
  output logic [DATA_W_P-1:0] o_Imm32_ID_EX,
  output logic                o_RegWr_ID_EX,
  output logic                o_ALUSrc_ID_EX,
  output logic                o_MemWr_ID_EX,
  output logic                o_MemtoReg_ID_EX,
  output logic                o_Valid_ID_EX,
  output logic [ALUC_W_P-1:0] o_ALUctr_ID_EX,
`ifdef HAZARD_STATS_EN
  output logic [CNT_W-1:0]    o_StallCnt,
  output logic [CNT_W-1:0]    o_FlushCnt,
`endif
  output logic                o_Stall_PC,
  output logic                o_Stall_IF_ID
);

  hz_state_e           r_state;
  ctrl_t               r_ctrl;
  logic [REG_W_P-1:0]  r_rs;
  logic [REG_W_P-1:0]  r_rt;
  logic [REG_W_P-1:0]  r_target;
  logic [DATA_W_P-1:0] r_bus_a;
  logic [DATA_W_P-1:0] r_bus_b;
  logic [DATA_W_P-1:0] r_imm;
  logic [ALUC_W_P-1:0] r_aluctr;
  logic                w_load_use;
  logic                w_bubble_in;

  load_use_detect #(.REG_W_P(REG_W_P)) u_lud (
    .i_Valid_ID        (i_Valid_ID),
    .i_Rs_ID           (i_Rs_ID),
    .i_Rt_ID           (i_Rt_ID),
    .i_UsesRs_ID       (i_UsesRs_ID),
    .i_UsesRt_ID       (i_UsesRt_ID),
    .i_MemtoReg_ID_EX  (r_ctrl.mem_to_reg),
    .i_RegWr_ID_EX     (r_ctrl.reg_wr),
    .i_Valid_ID_EX     (r_ctrl.valid),
    .i_RegTarget_ID_EX (r_target),
    .o_LoadUse         (w_load_use)
  );

  // Flush outranks both hold and the interlock, so it always releases the front end.
  assign o_Stall_PC    = ~i_Flush_ID_EX & (i_Hold | w_load_use);
  assign o_Stall_IF_ID = ~i_Flush_ID_EX & (i_Hold | w_load_use);
  assign w_bubble_in   = i_Flush_ID_EX | w_load_use | ~i_Valid_ID;

  // Pipeline register and RUN/BUBBLE state; hold leaves everything untouched.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state  <= ST_RUN;
      r_ctrl   <= BUBBLE_CTRL;
      r_rs     <= {REG_W_P{1'b0}};
      r_rt     <= {REG_W_P{1'b0}};
      r_target <= {REG_W_P{1'b0}};
      r_bus_a  <= {DATA_W_P{1'b0}};
      r_bus_b  <= {DATA_W_P{1'b0}};
      r_imm    <= {DATA_W_P{1'b0}};
      r_aluctr <= {ALUC_W_P{1'b0}};
    end else if (i_Hold && !i_Flush_ID_EX) begin
      r_state <= r_state;
    end else begin
      r_state <= (w_load_use && !i_Flush_ID_EX) ? ST_BUBBLE : ST_RUN;
      if (w_bubble_in) begin
        r_ctrl   <= BUBBLE_CTRL;
        r_rs     <= {REG_W_P{1'b0}};
        r_rt     <= {REG_W_P{1'b0}};
        r_target <= {REG_W_P{1'b0}};
        r_bus_a  <= {DATA_W_P{1'b0}};
        r_bus_b  <= {DATA_W_P{1'b0}};
        r_imm    <= {DATA_W_P{1'b0}};
        r_aluctr <= {ALUC_W_P{1'b0}};
      end else begin
        r_ctrl   <= '{reg_wr: i_RegWr_ID, alu_src: i_ALUSrc_ID, mem_wr: i_MemWr_ID,
                      mem_to_reg: i_MemtoReg_ID, valid: 1'b1};
        r_rs     <= i_Rs_ID;
        r_rt     <= i_Rt_ID;
        r_target <= i_RegDst_ID ? i_Rd_ID : i_Rt_ID;
        r_bus_a  <= i_BusA_ID;
        r_bus_b  <= i_BusB_ID;
        r_imm    <= i_Imm32_ID;
        r_aluctr <= i_ALUctr_ID;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating event counters; neither advances while the pipeline is held.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
    end else if (i_Hold) begin
      r_stall_cnt <= r_stall_cnt;
      r_flush_cnt <= r_flush_cnt;
    end else begin
      if (w_load_use && !i_Flush_ID_EX && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (i_Flush_ID_EX && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  assign o_StallCnt = r_stall_cnt;
  assign o_FlushCnt = r_flush_cnt;
`endif

  assign o_Rs_ID_EX        = r_rs;
  assign o_Rt_ID_EX        = r_rt;
  assign o_RegTarget_ID_EX = r_target;
  assign o_BusA_ID_EX      = r_bus_a;
  assign o_BusB_ID_EX      = r_bus_b;
  assign o_Imm32_ID_EX     = r_imm;
  assign o_RegWr_ID_EX     = r_ctrl.reg_wr;
  assign o_ALUSrc_ID_EX    = r_ctrl.alu_src;
  assign o_MemWr_ID_EX     = r_ctrl.mem_wr;
  assign o_MemtoReg_ID_EX  = r_ctrl.mem_to_reg;
  assign o_Valid_ID_EX     = r_ctrl.valid;
  assign o_ALUctr_ID_EX    = r_aluctr;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed self-checking bench for id_ex_hazard_stage; define HAZARD_STATS_EN to
// also exercise the saturating counters (built with CNT_W=2).
module tb_id_ex_hazard_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_id;
  logic [4:0]  rs_id, rt_id, rd_id;
  logic        uses_rs, uses_rt;
  logic [31:0] bus_a, bus_b, imm;
  logic        reg_wr, reg_dst, alu_src, mem_wr, mem_to_reg;
  logic [3:0]  aluctr;
  logic        flush, hold;
  logic [4:0]  rs_q, rt_q, tgt_q;
  logic [31:0] bus_a_q, bus_b_q, imm_q;
  logic        reg_wr_q, alu_src_q, mem_wr_q, mem_to_reg_q, valid_q;
  logic [3:0]  aluctr_q;
  logic        stall_pc, stall_ifid;
`ifdef HAZARD_STATS_EN
  logic [1:0]  stall_cnt, flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_hazard_stage #(.CNT_W(2)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Valid_ID(valid_id),
    .i_Rs_ID(rs_id), .i_Rt_ID(rt_id), .i_Rd_ID(rd_id),
    .i_UsesRs_ID(uses_rs), .i_UsesRt_ID(uses_rt),
    .i_BusA_ID(bus_a), .i_BusB_ID(bus_b), .i_Imm32_ID(imm),
    .i_RegWr_ID(reg_wr), .i_RegDst_ID(reg_dst), .i_ALUSrc_ID(alu_src),
    .i_MemWr_ID(mem_wr), .i_MemtoReg_ID(mem_to_reg), .i_ALUctr_ID(aluctr),
    .i_Flush_ID_EX(flush), .i_Hold(hold),
    .o_Rs_ID_EX(rs_q), .o_Rt_ID_EX(rt_q), .o_RegTarget_ID_EX(tgt_q),
    .o_BusA_ID_EX(bus_a_q), .o_BusB_ID_EX(bus_b_q), .o_Imm32_ID_EX(imm_q),
    .o_RegWr_ID_EX(reg_wr_q), .o_ALUSrc_ID_EX(alu_src_q), .o_MemWr_ID_EX(mem_wr_q),
    .o_MemtoReg_ID_EX(mem_to_reg_q), .o_Valid_ID_EX(valid_q), .o_ALUctr_ID_EX(aluctr_q),
`ifdef HAZARD_STATS_EN
    .o_StallCnt(stall_cnt), .o_FlushCnt(flush_cnt),
`endif
    .o_Stall_PC(stall_pc), .o_Stall_IF_ID(stall_ifid)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    valid_id = 1'b0; rs_id = 5'd0; rt_id = 5'd0; rd_id = 5'd0;
    uses_rs = 1'b0; uses_rt = 1'b0; bus_a = 32'd0; bus_b = 32'd0; imm = 32'd0;
    reg_wr = 1'b0; reg_dst = 1'b0; alu_src = 1'b0; mem_wr = 1'b0; mem_to_reg = 1'b0;
    aluctr = 4'd0;
  endtask

  // lw $rt, 4($1)
  task automatic set_lw(input logic [4:0] rt);
    set_nop();
    valid_id = 1'b1; rs_id = 5'd1; rt_id = rt; uses_rs = 1'b1;
    reg_wr = 1'b1; alu_src = 1'b1; mem_to_reg = 1'b1; aluctr = 4'd2; imm = 32'd4;
    bus_a = 32'h0000_1000;
  endtask

  // add $rd, $rs, $rt
  task automatic set_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    set_nop();
    valid_id = 1'b1; rs_id = rs; rt_id = rt; rd_id = rd; uses_rs = 1'b1; uses_rt = 1'b1;
    reg_wr = 1'b1; reg_dst = 1'b1; aluctr = 4'd2;
    bus_a = 32'hA5A5_0001; bus_b = 32'h0000_0022;
  endtask

  initial begin
    set_nop();
    flush = 1'b0; hold = 1'b0; rst = 1'b1;
    #2;
    step();
    step();
    rst = 1'b0;
    #1;
    check_eq("rst_valid", valid_q, 1'b0);
    check_eq("rst_regwr", reg_wr_q, 1'b0);
    check_eq("rst_target", tgt_q, 5'd0);
    check_eq("rst_stall", stall_pc, 1'b0);

    // 1: lw $8 ; add $9,$8,$2
    set_lw(5'd8);
    step();
    check_eq("t1_lw_target", tgt_q, 5'd8);
    check_eq("t1_lw_memtoreg", mem_to_reg_q, 1'b1);
    check_eq("t1_lw_imm", imm_q, 32'd4);
    set_add(5'd9, 5'd8, 5'd2);
    #1;
    check_eq("t1_stall_pc", stall_pc, 1'b1);
    check_eq("t1_stall_ifid", stall_ifid, 1'b1);
    step();
    check_eq("t1_bubble_valid", valid_q, 1'b0);
    check_eq("t1_bubble_regwr", reg_wr_q, 1'b0);
    check_eq("t1_stall_released", stall_pc, 1'b0);
    step();
    check_eq("t1_add_valid", valid_q, 1'b1);
    check_eq("t1_add_target", tgt_q, 5'd9);
    check_eq("t1_add_rs", rs_q, 5'd8);
    check_eq("t1_add_busa", bus_a_q, 32'hA5A5_0001);
    check_eq("t1_add_memtoreg", mem_to_reg_q, 1'b0);

    // 2: $0 target never stalls; unused Rt never stalls
    set_lw(5'd0);
    step();
    set_add(5'd9, 5'd0, 5'd0);
    #1;
    check_eq("t2_r0_nostall", stall_pc, 1'b0);
    step();
    check_eq("t2_r0_add_valid", valid_q, 1'b1);
    set_lw(5'd8);
    step();
    set_add(5'd7, 5'd3, 5'd8);
    uses_rt = 1'b1;
    #1;
    check_eq("t2_rt_stall", stall_pc, 1'b1);
    uses_rt = 1'b0; reg_dst = 1'b0;
    #1;
    check_eq("t2_unused_rt_nostall", stall_pc, 1'b0);
    valid_id = 1'b0; uses_rs = 1'b1; rs_id = 5'd8;
    #1;
    check_eq("t2_invalid_id_nostall", stall_pc, 1'b0);
    valid_id = 1'b1; rs_id = 5'd3;
    step();
    check_eq("t2_addi_target_rt", tgt_q, 5'd8);
    check_eq("t2_addi_valid", valid_q, 1'b1);

    // 3: flush in the same cycle as a load-use
    set_lw(5'd8);
    step();
    set_add(5'd9, 5'd8, 5'd2);
    flush = 1'b1;
    #1;
    check_eq("t3_flush_stall_pc", stall_pc, 1'b0);
    check_eq("t3_flush_stall_ifid", stall_ifid, 1'b0);
    step();
    flush = 1'b0;
    check_eq("t3_flush_valid", valid_q, 1'b0);
    check_eq("t3_flush_memtoreg", mem_to_reg_q, 1'b0);
`ifdef HAZARD_STATS_EN
    check_eq("t3_stallcnt_same", stall_cnt, 2'd1);
    check_eq("t3_flushcnt", flush_cnt, 2'd1);
`endif
    #1;
    check_eq("t3_no_stall_after", stall_pc, 1'b0);
    step();
    check_eq("t3_add_after_flush", tgt_q, 5'd9);

    // 4: hold for 3 cycles in the middle of a stall
    set_lw(5'd8);
    step();
    set_add(5'd9, 5'd8, 5'd2);
    step();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t4_hold_stall_pc", stall_pc, 1'b1);
      check_eq("t4_hold_stall_ifid", stall_ifid, 1'b1);
      step();
      check_eq("t4_hold_frozen_valid", valid_q, 1'b0);
    end
    hold = 1'b0;
    #1;
    check_eq("t4_release_stall", stall_pc, 1'b0);
    step();
    check_eq("t4_add_after_hold", tgt_q, 5'd9);
    check_eq("t4_add_valid", valid_q, 1'b1);
    hold = 1'b1;
    set_nop();
    step();
    check_eq("t4_hold_keeps_add", tgt_q, 5'd9);
    check_eq("t4_hold_keeps_busb", bus_b_q, 32'h0000_0022);
    hold = 1'b0;

    // 5: reset while in BUBBLE
    set_lw(5'd8);
    step();
    set_add(5'd9, 5'd8, 5'd2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_nop();
    #1;
    check_eq("t5_rst_valid", valid_q, 1'b0);
    check_eq("t5_rst_busa", bus_a_q, 32'd0);
    check_eq("t5_rst_stall", stall_pc, 1'b0);
`ifdef HAZARD_STATS_EN
    check_eq("t5_rst_stallcnt", stall_cnt, 2'd0);
    check_eq("t5_rst_flushcnt", flush_cnt, 2'd0);
`endif
    set_lw(5'd8);
    step();
    set_add(5'd9, 5'd8, 5'd2);
    #1;
    check_eq("t5_run_after_rst_stall", stall_pc, 1'b1);
    step();
    step();
    check_eq("t5_add_after_rst", tgt_q, 5'd9);

`ifdef HAZARD_STATS_EN
    // 6: saturation after 5 load-use events
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_lw(5'd8);
      step();
      set_add(5'd9, 5'd8, 5'd2);
      step();
      step();
    end
    check_eq("t6_stallcnt_sat", stall_cnt, 2'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
